// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed seven-segment scan driver with shadowed display word
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lzs;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    blank_phase;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick = (cnt == CNT_MAX);

  generate
    if (BLANK > 0) begin : g_blank
      assign blank_phase = (cnt < CNT_W'(BLANK));
    end else begin : g_no_blank
      assign blank_phase = 1'b0;
    end
  endgenerate

  // Walk from the most significant digit down so zero_above covers nibbles i..NUM_DIGITS-1.
  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]     = sh_value[4*i +: 4];
      zero_above = zero_above && (nib[i] == 4'd0);
      supp[i]    = !sh_en[i] || (sh_lzs && (i != 0) && zero_above);
    end
  end

  assign cur_nib = nib[idx];

  always_comb begin
    cur_seg = 7'b1111111;
    case (cur_nib)
      4'h0: cur_seg = 7'b0000001;
      4'h1: cur_seg = 7'b1001111;
      4'h2: cur_seg = 7'b0010010;
      4'h3: cur_seg = 7'b0000110;
      4'h4: cur_seg = 7'b1001100;
      4'h5: cur_seg = 7'b0100100;
      4'h6: cur_seg = 7'b0100000;
      4'h7: cur_seg = 7'b0001111;
      4'h8: cur_seg = 7'b0000000;
      4'h9: cur_seg = 7'b0000100;
      4'hA: cur_seg = 7'b0001000;
      4'hB: cur_seg = 7'b1100000;
      4'hC: cur_seg = 7'b0110001;
      4'hD: cur_seg = 7'b1000010;
      4'hE: cur_seg = 7'b0110000;
      4'hF: cur_seg = 7'b0111000;
      default: cur_seg = 7'b1111111;
    endcase
  end

  // A suppressed digit keeps its anode low for the slot; only the segments go dark.
  always_comb begin
    an_next  = '1;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (!blank_phase) begin
      an_next = ~(NUM_DIGITS'(1) << idx);
      if (!supp[idx]) begin
        seg_next = cur_seg;
        dp_next  = ~sh_dp[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_lzs     <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_en    <= digit_en;
        sh_lzs   <= lzs;
      end
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      frame_done <= tick && (idx == IDX_MAX);
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
    end
  end

endmodule
